// File: rtl/fiforam_rd_sched.sv
// Read-side scheduler for the shared FIFORAM line buffer: round-robin grant of
// single-word reads, response routing, and per-entry pass counting with head pop.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   S_IDLE | no read outstanding; grant and issue a read this cycle
//   S_WAIT | read issued, waiting for rvalid or the timeout to expire
//   S_POP  | reuse count reached; pop the FIFORAM head for one cycle
module fiforam_rd_sched #(
    parameter int NREQ    = 4,
    parameter int DW      = 16,
    parameter int PASSBW  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req_rdy,
    input  logic [NREQ-1:0]   i_req_last,
    output logic [NREQ-1:0]   o_req_ack,
    output logic [NREQ-1:0]   o_rsp_dval,
    output logic [DW-1:0]     o_rsp_data,
    output logic              o_ram_read,
    output logic              o_ram_lastpix,
    output logic              o_ram_pop,
    input  logic [DW-1:0]     i_ram_rdata,
    input  logic              i_ram_rvalid,
    input  logic [PASSBW-1:0] i_pass_num,
    output logic [PASSBW-1:0] o_pass_cnt,
    output logic              o_busy,
    output logic              o_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW:0]       NREQ_W   = (PW + 1)'(NREQ);
    localparam logic [PW-1:0]     LAST_IDX = PW'(NREQ - 1);
    localparam logic [TW-1:0]     TMO_LOAD = TW'(TIMEOUT - 1);
    localparam logic [PASSBW-1:0] PASS_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_POP} state_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       gnt_q;
    logic                last_q;
    logic [PASSBW-1:0]   pass_cnt;
    logic [TW-1:0]       tmo_cnt;
    logic                err_q;
    logic [NREQ-1:0]     rsp_dval;
    logic [DW-1:0]       rsp_data;

    logic [2*NREQ-1:0]   rdy_dbl;
    logic [NREQ-1:0]     rdy_rot;
    logic                gnt_vld;
    logic [PW-1:0]       gnt_off;
    logic [PW:0]         gnt_sum;
    logic [PW-1:0]       gnt_idx;
    logic                gnt_fire;
    logic [PASSBW-1:0]   pass_inc;
    logic [PASSBW-1:0]   pass_lim;

    // Rotate requests so bit 0 is rr_ptr; the first set bit is the grant offset.
    assign rdy_dbl = {i_req_rdy, i_req_rdy} >> rr_ptr;
    assign rdy_rot = rdy_dbl[NREQ-1:0];

    // Round-robin search: first pending requester at or after rr_ptr, with wrap.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_off = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_vld && rdy_rot[i]) begin
                gnt_vld = 1'b1;
                gnt_off = PW'(i);
            end
        end
        gnt_sum = {1'b0, rr_ptr} + {1'b0, gnt_off};
        gnt_idx = (gnt_sum >= NREQ_W) ? PW'(gnt_sum - NREQ_W) : gnt_sum[PW-1:0];
    end

    assign pass_inc = (pass_cnt == PASS_MAX) ? pass_cnt : pass_cnt + 1'b1;
    assign pass_lim = (i_pass_num == '0) ? PASSBW'(1) : i_pass_num;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state and grant-cycle strobes; strobes held low while in reset.
    always_comb begin
        state_nxt     = state;
        gnt_fire      = 1'b0;
        o_req_ack     = '0;
        o_ram_read    = 1'b0;
        o_ram_lastpix = 1'b0;
        o_ram_pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (gnt_vld && !i_rst) begin
                    gnt_fire      = 1'b1;
                    o_req_ack     = NREQ'(1) << gnt_idx;
                    o_ram_read    = 1'b1;
                    o_ram_lastpix = i_req_last[gnt_idx];
                    state_nxt     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_ram_rvalid) begin
                    if (last_q && (pass_inc >= pass_lim)) state_nxt = S_POP;
                    else                                  state_nxt = S_IDLE;
                end else if (tmo_cnt == '0) begin
                    state_nxt = S_IDLE;
                end
            end
            S_POP: begin
                o_ram_pop = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant bookkeeping, timeout down-counter, response register and pass count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr   <= '0;
            gnt_q    <= '0;
            last_q   <= 1'b0;
            pass_cnt <= '0;
            tmo_cnt  <= '0;
            err_q    <= 1'b0;
            rsp_dval <= '0;
            rsp_data <= '0;
        end else begin
            rsp_dval <= '0;
            if (gnt_fire) begin
                gnt_q   <= gnt_idx;
                last_q  <= i_req_last[gnt_idx];
                rr_ptr  <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
                tmo_cnt <= TMO_LOAD;
            end
            if (state == S_WAIT) begin
                if (i_ram_rvalid) begin
                    rsp_dval <= NREQ'(1) << gnt_q;
                    rsp_data <= i_ram_rdata;
                    if (last_q) pass_cnt <= pass_inc;
                end else if (tmo_cnt == '0) begin
                    err_q <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt - 1'b1;
                end
            end
            if (state == S_POP) pass_cnt <= '0;
        end
    end

    assign o_rsp_dval = rsp_dval;
    assign o_rsp_data = rsp_data;
    assign o_pass_cnt = pass_cnt;
    assign o_err      = err_q;
    // Busy also covers the cycle in which the response is handed to the consumer.
    assign o_busy     = (state != S_IDLE) || (|rsp_dval);

endmodule

// File: tb/tb_fiforam_rd_sched.sv
// Bench for fiforam_rd_sched: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then a randomized run.
module tb_fiforam_rd_sched;

    localparam int NREQ = 4, DW = 16, PASSBW = 4, TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              i_rst = 1'b1;
    logic [NREQ-1:0]   i_req_rdy = '0, i_req_last = '0;
    logic [NREQ-1:0]   o_req_ack, o_rsp_dval;
    logic [DW-1:0]     o_rsp_data;
    logic              o_ram_read, o_ram_lastpix, o_ram_pop;
    logic [DW-1:0]     i_ram_rdata = '0;
    logic              i_ram_rvalid = 1'b0;
    logic [PASSBW-1:0] i_pass_num = '0;
    logic [PASSBW-1:0] o_pass_cnt;
    logic              o_busy, o_err;

    fiforam_rd_sched #(.NREQ(NREQ), .DW(DW), .PASSBW(PASSBW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_req_rdy(i_req_rdy), .i_req_last(i_req_last),
        .o_req_ack(o_req_ack), .o_rsp_dval(o_rsp_dval), .o_rsp_data(o_rsp_data),
        .o_ram_read(o_ram_read), .o_ram_lastpix(o_ram_lastpix), .o_ram_pop(o_ram_pop),
        .i_ram_rdata(i_ram_rdata), .i_ram_rvalid(i_ram_rvalid), .i_pass_num(i_pass_num),
        .o_pass_cnt(o_pass_cnt), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    // Reference model: one outstanding read, a response slot, a pending pop.
    int              m_ptr = 0, m_gnt = 0, m_waited = 0, m_rsp_idx = 0, m_pass = 0, m_cur_g = -1;
    bit              m_inflight = 0, m_last = 0, m_rsp_valid = 0, m_pop_now = 0, m_err = 0;
    logic [DW-1:0]   m_data = '0;
    logic [NREQ-1:0] e_ack_now = '0;
    bit              e_read_now = 0;
    int              ram_cnt = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check();
        int g;
        logic [NREQ-1:0] ed;
        g = -1;
        if (!m_inflight && !m_pop_now && !i_rst)
            for (int i = 0; i < NREQ; i++)
                if (g < 0 && i_req_rdy[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
        m_cur_g    = g;
        e_read_now = (g >= 0);
        e_ack_now  = (g >= 0) ? NREQ'(1) << g : '0;
        ed         = m_rsp_valid ? NREQ'(1) << m_rsp_idx : '0;
        chk("ack", o_req_ack, e_ack_now);
        chk("ram_read", o_ram_read, e_read_now);
        chk("lastpix", o_ram_lastpix, (g >= 0) ? i_req_last[g] : 1'b0);
        chk("rsp_dval", o_rsp_dval, ed);
        chk("rsp_data", o_rsp_data, m_data);
        chk("ram_pop", o_ram_pop, m_pop_now);
        chk("pass_cnt", o_pass_cnt, m_pass);
        chk("busy", o_busy, m_inflight || m_pop_now || m_rsp_valid);
        chk("err", o_err, m_err);
    endtask

    task automatic advance();
        bit had_pop;
        int lim;
        if (i_rst) begin
            m_ptr = 0; m_inflight = 0; m_rsp_valid = 0; m_pop_now = 0;
            m_pass = 0; m_err = 0; m_data = '0;
            return;
        end
        had_pop = m_pop_now;
        m_rsp_valid = 0;
        m_pop_now = 0;
        lim = (i_pass_num == 0) ? 1 : int'(i_pass_num);
        if (m_inflight) begin
            m_waited++;
            if (i_ram_rvalid) begin
                m_rsp_valid = 1; m_rsp_idx = m_gnt; m_data = i_ram_rdata; m_inflight = 0;
                if (m_last) begin
                    if (m_pass < 2**PASSBW - 1) m_pass++;
                    if (m_pass >= lim) m_pop_now = 1;
                end
            end else if (m_waited == TIMEOUT) begin
                m_err = 1; m_inflight = 0;
            end
        end else if (had_pop) begin
            m_pass = 0;
        end else if (m_cur_g >= 0) begin
            m_inflight = 1; m_gnt = m_cur_g; m_last = i_req_last[m_cur_g];
            m_waited = 0; m_ptr = (m_cur_g + 1) % NREQ;
        end
    endtask

    task automatic cyc_a(); #1; check(); endtask
    task automatic cyc_b(); advance(); @(negedge clk); endtask
    task automatic cyc();   cyc_a(); cyc_b(); endtask

    task automatic do_reset();
        i_req_rdy = '0; i_req_last = '0; i_ram_rvalid = 0;
        i_rst = 1; cyc(); cyc(); i_rst = 0;
    endtask

    // One read by requester r; RAM answers k cycles after the ack with data d.
    task automatic do_read(input int r, input bit last, input int k, input logic [DW-1:0] d);
        i_req_rdy = NREQ'(1) << r; i_req_last = NREQ'(last) << r; i_ram_rvalid = 0;
        cyc_a();
        chk("rd_ack", o_req_ack, NREQ'(1) << r);
        chk("rd_lastpix", o_ram_lastpix, last);
        cyc_b();
        i_req_rdy = '0; i_req_last = '0;
        for (int i = 1; i < k; i++) cyc();
        i_ram_rvalid = 1; i_ram_rdata = d; cyc(); i_ram_rvalid = 0;
    endtask

    initial begin
        int gs[5];
        int ng, budget;
        repeat (2) @(negedge clk);
        do_reset();
        cyc_a();
        chk("rst_ack", o_req_ack, 0); chk("rst_busy", o_busy, 0); chk("rst_err", o_err, 0);
        cyc_b();

        // Single requester, rvalid at T+2.
        i_req_rdy = 4'b0001; cyc_a(); chk("s_ack", o_req_ack, 4'b0001); chk("s_read", o_ram_read, 1); cyc_b();
        i_req_rdy = '0; cyc_a(); chk("s_busy1", o_busy, 1); cyc_b();
        i_ram_rvalid = 1; i_ram_rdata = 16'h1234; cyc_a(); chk("s_busy2", o_busy, 1); cyc_b();
        i_ram_rvalid = 0;
        cyc_a(); chk("s_dval", o_rsp_dval, 4'b0001); chk("s_data", o_rsp_data, 16'h1234); chk("s_busy3", o_busy, 1); cyc_b();
        cyc_a(); chk("s_hold", o_rsp_data, 16'h1234); chk("s_idle", o_busy, 0); cyc_b();

        // All requesters continuously ready.
        do_reset();
        ng = 0; budget = 0;
        i_req_rdy = '1;
        while (ng < 5 && budget < 40) begin
            i_ram_rvalid = m_inflight; i_ram_rdata = DW'($urandom);
            cyc_a();
            if (o_req_ack != 0) begin gs[ng] = $clog2(int'(o_req_ack)); ng++; end
            cyc_b();
            budget++;
        end
        chk("rr_count", ng, 5);
        for (int i = 0; i < ng; i++) chk("rr_order", gs[i], i % NREQ);
        i_req_rdy = '0; i_ram_rvalid = m_inflight; cyc(); i_ram_rvalid = 0; cyc();

        // Three passes before pop.
        do_reset();
        i_pass_num = 3;
        do_read(0, 1, 2, 16'h0a01); cyc_a(); chk("p_cnt1", o_pass_cnt, 1); chk("p_nopop1", o_ram_pop, 0); cyc_b();
        do_read(0, 1, 1, 16'h0a02); cyc_a(); chk("p_cnt2", o_pass_cnt, 2); chk("p_nopop2", o_ram_pop, 0); cyc_b();
        do_read(0, 1, 3, 16'h0a03); cyc_a(); chk("p_pop", o_ram_pop, 1); chk("p_dval", o_rsp_dval, 4'b0001); cyc_b();
        cyc_a(); chk("p_cnt0", o_pass_cnt, 0); chk("p_pop_off", o_ram_pop, 0); cyc_b();

        // Pass count of zero behaves as one.
        i_pass_num = 0;
        do_read(1, 1, 1, 16'h0b00); cyc_a(); chk("p0_pop", o_ram_pop, 1); cyc_b();
        cyc_a(); chk("p0_cnt", o_pass_cnt, 0); cyc_b();

        // Timeout, spurious rvalid, recovery, sticky error.
        do_reset();
        i_pass_num = 1;
        i_req_rdy = 4'b0001; cyc_a(); chk("t_ack", o_req_ack, 4'b0001); cyc_b();
        i_req_rdy = '0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            cyc_a(); if (i == TIMEOUT) chk("t_err_pre", o_err, 0); cyc_b();
        end
        cyc_a(); chk("t_err", o_err, 1); chk("t_busy", o_busy, 0); chk("t_nodval", o_rsp_dval, 0); cyc_b();
        i_ram_rvalid = 1; i_ram_rdata = 16'hdead; cyc(); i_ram_rvalid = 0;
        cyc_a(); chk("t_spur", o_rsp_dval, 0); chk("t_err_hold", o_err, 1); cyc_b();
        do_read(1, 0, 3, 16'hbeef);
        cyc_a(); chk("t_dval", o_rsp_dval, 4'b0010); chk("t_data", o_rsp_data, 16'hbeef); chk("t_err_st", o_err, 1); cyc_b();
        do_reset();
        cyc_a(); chk("t_err_clr", o_err, 0); cyc_b();

        // Reset while waiting for read data.
        i_pass_num = 1;
        do_read(3, 1, 1, 16'h0003); cyc();
        i_req_rdy = 4'b0100; i_req_last = 4'b0100; cyc_a(); chk("r_ack", o_req_ack, 4'b0100); cyc_b();
        i_req_rdy = '0; i_req_last = '0; cyc();
        i_rst = 1; cyc(); i_rst = 0;
        i_ram_rvalid = 1; i_ram_rdata = 16'h5555;
        cyc_a(); chk("r_dval", o_rsp_dval, 0); chk("r_busy", o_busy, 0); chk("r_cnt", o_pass_cnt, 0); chk("r_data", o_rsp_data, 0); cyc_b();
        i_ram_rvalid = 0;
        cyc_a(); chk("r_nodval", o_rsp_dval, 0); cyc_b();
        i_req_rdy = '1; cyc_a(); chk("r_ptr0", o_req_ack, 4'b0001); cyc_b();
        i_req_rdy = '0;

        // Randomized traffic.
        ram_cnt = 1;
        for (int c = 0; c < 4000; c++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (e_ack_now[r]) i_req_rdy[r] = 0;
                if (!i_req_rdy[r]) begin
                    if ($urandom_range(3) == 0) begin
                        i_req_rdy[r] = 1; i_req_last[r] = ($urandom_range(2) == 0);
                    end
                end else if ($urandom_range(39) == 0) i_req_rdy[r] = 0;
            end
            if (m_inflight) begin
                ram_cnt--;
                i_ram_rvalid = (ram_cnt == 0);
            end else i_ram_rvalid = ($urandom_range(9) == 0);
            i_ram_rdata = DW'($urandom);
            if ($urandom_range(99) == 0) i_pass_num = PASSBW'($urandom_range(4));
            i_rst = ($urandom_range(399) == 0);
            cyc_a();
            if (e_read_now) ram_cnt = ($urandom_range(49) == 0) ? 1000 : $urandom_range(1, 5);
            cyc_b();
        end
        i_rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
